// File: rtl/spi_sram_responder.sv
// spi_sram_responder
//   SPI mode-0 responder emulating the 23LC1024 serial SRAM command set
//   (READ 0x03, WRITE 0x02, RDMR 0x05, WRMR 0x01) on an internal block RAM.
//   CSn, SCK and SI are oversampled in the clk domain; nothing is clocked by SCK.
//
// Ports:
//   clk       system clock, at least 8x the SCK frequency
//   rst       synchronous active-high reset (RAM contents are kept)
//   CSn       chip select, active low, asynchronous to clk
//   SCK       SPI clock, asynchronous to clk
//   SI        serial data in, MSB first
//   SO        serial data out, MSB first, changes only after an SCK fall
//   busy      high while synchronised CSn is low
//   mode_reg  current mode register (bits 7:6 select address advance)
//   bad_cmd   one-cycle pulse when an unsupported opcode completes
module spi_sram_responder #(
  parameter int ADDR_BITS  = 10,
  parameter int PAGE_BYTES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       CSn,
  input  logic       SCK,
  input  logic       SI,
  output logic       SO,
  output logic       busy,
  output logic [7:0] mode_reg,
  output logic       bad_cmd
);

  localparam int                   DEPTH      = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] PAGE_MASK  = ADDR_BITS'(PAGE_BYTES - 1);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE   = ADDR_BITS'(1);
  localparam logic [7:0]           OP_WRMR    = 8'h01;
  localparam logic [7:0]           OP_WRITE   = 8'h02;
  localparam logic [7:0]           OP_READ    = 8'h03;
  localparam logic [7:0]           OP_RDMR    = 8'h05;
  localparam logic [7:0]           MODE_RESET = 8'h40;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_WR_DATA = 3'd4,
    ST_RDMR    = 3'd5,
    ST_WRMR    = 3'd6,
    ST_IGNORE  = 3'd7
  } state_t;

  // Address advance after a completed byte: 00 hold, 10 wrap inside the page,
  // 01/11 linear wrap over the whole RAM.
  function automatic logic [ADDR_BITS-1:0] f_addr_adv(
    input logic [ADDR_BITS-1:0] addr,
    input logic [1:0]           mode
  );
    logic [ADDR_BITS-1:0] inc;
    inc = addr + ADDR_ONE;
    case (mode)
      2'b00:   f_addr_adv = addr;
      2'b10:   f_addr_adv = (addr & ~PAGE_MASK) | (inc & PAGE_MASK);
      default: f_addr_adv = inc;
    endcase
  endfunction

  // Synchroniser and edge-history flops
  logic r_csn_meta, r_csn_sync, r_csn_prev;
  logic r_sck_meta, r_sck_sync, r_sck_prev;
  logic r_si_meta, r_si_sync;

  // Control and datapath registers
  state_t               r_state;
  logic [4:0]           r_bit_cnt;
  logic [6:0]           r_shift;
  logic [ADDR_BITS-1:0] r_addr;
  logic [7:0]           r_tx;
  logic                 r_so;
  logic [7:0]           r_mode;
  logic                 r_is_read;
  logic                 r_hold;
  logic                 r_bad_cmd;
  logic                 r_busy;
  logic [7:0]           r_mem [0:DEPTH-1];
  logic [7:0]           r_mem_q;

  // Combinational wires
  state_t               w_state_nxt;
  logic                 w_bad_nxt;
  logic                 w_mem_we;
  logic                 w_mem_re;
  logic [ADDR_BITS-1:0] w_mem_raddr;
  logic                 w_sck_rise, w_sck_fall, w_csn_rise, w_csn_fall;
  logic                 w_byte_end, w_addr_end;
  logic [4:0]           w_cnt8_nxt;
  logic [7:0]           w_shift_nxt;
  logic [ADDR_BITS-1:0] w_addr_nxt;
  logic [ADDR_BITS-1:0] w_addr_adv;
  logic                 w_hold_nxt;
  logic [7:0]           w_load_byte;
  logic [7:0]           w_tx_src;

  assign w_sck_rise  = r_sck_sync & ~r_sck_prev;
  assign w_sck_fall  = ~r_sck_sync & r_sck_prev;
  assign w_csn_rise  = r_csn_sync & ~r_csn_prev;
  assign w_csn_fall  = ~r_csn_sync & r_csn_prev;
  assign w_byte_end  = (r_bit_cnt == 5'd7);
  assign w_addr_end  = (r_bit_cnt == 5'd23);
  assign w_cnt8_nxt  = w_byte_end ? 5'd0 : (r_bit_cnt + 5'd1);
  assign w_shift_nxt = {r_shift, r_si_sync};
  assign w_addr_nxt  = {r_addr[ADDR_BITS-2:0], r_si_sync};
  assign w_addr_adv  = f_addr_adv(r_addr, r_mode[7:6]);
  // In byte mode only the first data byte of a transfer is live
  assign w_hold_nxt  = r_hold | (r_mode[7:6] == 2'b00);
  assign w_load_byte = (r_state == ST_RDMR) ? r_mode : (r_hold ? 8'h00 : r_mem_q);
  // First falling edge of each byte loads a fresh byte, later ones shift
  assign w_tx_src    = (r_bit_cnt == 5'd0) ? w_load_byte : r_tx;

  // Two-flop synchronisers; left unreset so that a CSn held low through rst
  // never looks like a new falling edge afterwards.
  always_ff @(posedge clk) begin
    r_csn_meta <= CSn;
    r_csn_sync <= r_csn_meta;
    r_csn_prev <= r_csn_sync;
    r_sck_meta <= SCK;
    r_sck_sync <= r_sck_meta;
    r_sck_prev <= r_sck_sync;
    r_si_meta  <= SI;
    r_si_sync  <= r_si_meta;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus RAM strobes; a CSn rise overrides any SCK sample
  always_comb begin
    w_state_nxt = r_state;
    w_bad_nxt   = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_re    = 1'b0;
    w_mem_raddr = r_addr;
    if (w_csn_rise) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_csn_fall) begin
            w_state_nxt = ST_CMD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_CMD: begin
          if (w_sck_rise && w_byte_end) begin
            case (w_shift_nxt)
              OP_READ, OP_WRITE: w_state_nxt = ST_ADDR;
              OP_RDMR:           w_state_nxt = ST_RDMR;
              OP_WRMR:           w_state_nxt = ST_WRMR;
              default: begin
                w_state_nxt = ST_IGNORE;
                w_bad_nxt   = 1'b1;
              end
            endcase
          end else begin
            w_state_nxt = ST_CMD;
          end
        end
        ST_ADDR: begin
          if (w_sck_rise && w_addr_end) begin
            w_state_nxt = r_is_read ? ST_RD_DATA : ST_WR_DATA;
            w_mem_re    = r_is_read;
            w_mem_raddr = w_addr_nxt;
          end else begin
            w_state_nxt = ST_ADDR;
          end
        end
        ST_RD_DATA: begin
          // Prefetch the next byte well before its first falling edge
          if (w_sck_rise && w_byte_end) begin
            w_mem_re    = 1'b1;
            w_mem_raddr = w_addr_adv;
          end else begin
            w_mem_re    = 1'b0;
          end
        end
        ST_WR_DATA: begin
          if (w_sck_rise && w_byte_end && !r_hold) begin
            w_mem_we = 1'b1;
          end else begin
            w_mem_we = 1'b0;
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Bit counter, shift registers, address, mode register and output flops
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt <= 5'd0;
      r_shift   <= 7'd0;
      r_addr    <= '0;
      r_tx      <= 8'h00;
      r_so      <= 1'b0;
      r_mode    <= MODE_RESET;
      r_is_read <= 1'b0;
      r_hold    <= 1'b0;
      r_bad_cmd <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_bad_cmd <= w_bad_nxt;
      // Taken from the meta stage so it lines up with the synchronised CSn
      r_busy    <= ~r_csn_meta;
      if (w_csn_rise || (r_state == ST_IDLE)) begin
        r_bit_cnt <= 5'd0;
        r_hold    <= 1'b0;
        r_so      <= 1'b0;
      end else begin
        case (r_state)
          ST_CMD: begin
            if (w_sck_rise) begin
              r_shift   <= w_shift_nxt[6:0];
              r_bit_cnt <= w_cnt8_nxt;
              if (w_byte_end) begin
                r_is_read <= (w_shift_nxt == OP_READ);
              end
            end
          end
          ST_ADDR: begin
            if (w_sck_rise) begin
              r_addr    <= w_addr_nxt;
              r_bit_cnt <= w_addr_end ? 5'd0 : (r_bit_cnt + 5'd1);
            end
          end
          ST_RD_DATA, ST_RDMR: begin
            if (w_sck_rise) begin
              r_bit_cnt <= w_cnt8_nxt;
              if (w_byte_end && (r_state == ST_RD_DATA)) begin
                r_addr <= w_addr_adv;
                r_hold <= w_hold_nxt;
              end
            end else if (w_sck_fall) begin
              r_so <= w_tx_src[7];
              r_tx <= {w_tx_src[6:0], 1'b0};
            end
          end
          ST_WR_DATA: begin
            if (w_sck_rise) begin
              r_shift   <= w_shift_nxt[6:0];
              r_bit_cnt <= w_cnt8_nxt;
              if (w_byte_end) begin
                r_addr <= w_addr_adv;
                r_hold <= w_hold_nxt;
              end
            end
          end
          ST_WRMR: begin
            if (w_sck_rise) begin
              r_shift   <= w_shift_nxt[6:0];
              r_bit_cnt <= w_cnt8_nxt;
              if (w_byte_end) begin
                if (!r_hold) begin
                  r_mode <= w_shift_nxt;
                end
                r_hold <= 1'b1;
              end
            end
          end
          default: r_so <= 1'b0;
        endcase
      end
    end
  end

  // Block RAM: one write port, one registered read port, never cleared
  always_ff @(posedge clk) begin
    if (w_mem_we && !rst) begin
      r_mem[r_addr] <= w_shift_nxt;
    end
    if (w_mem_re) begin
      r_mem_q <= r_mem[w_mem_raddr];
    end
  end

  assign SO       = r_so;
  assign busy     = r_busy;
  assign mode_reg = r_mode;
  assign bad_cmd  = r_bad_cmd;

endmodule

// File: tb/tb_spi_sram_responder.sv
// tb_spi_sram_responder
//   Directed bench for spi_sram_responder: drives an SPI mode-0 master with
//   SCK edges aligned to clk falling edges and compares against hand-computed
//   bytes with immediate assertions.
module tb_spi_sram_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       CSn;
  logic       SCK;
  logic       SI;
  logic       SO;
  logic       busy;
  logic [7:0] mode_reg;
  logic       bad_cmd;

  int checks   = 0;
  int failures = 0;

  logic [7:0] bad_cnt     = 8'd0;
  logic [7:0] so_high_cnt = 8'd0;
  logic [7:0] rx;
  logic [7:0] snap;

  spi_sram_responder #(
    .ADDR_BITS (10),
    .PAGE_BYTES(32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .CSn     (CSn),
    .SCK     (SCK),
    .SI      (SI),
    .SO      (SO),
    .busy    (busy),
    .mode_reg(mode_reg),
    .bad_cmd (bad_cmd)
  );

  always #5 clk = ~clk;

  // Count bad_cmd pulse cycles and cycles with SO high
  always @(negedge clk) begin
    if (bad_cmd === 1'b1) bad_cnt <= bad_cnt + 8'd1;
    if (SO === 1'b1) so_high_cnt <= so_high_cnt + 8'd1;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  // Send the top n bits of tx; SO is sampled just before each rising edge
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      SI = tx[i];
      #40;
      r[i] = SO;
      SCK = 1'b1;
      #40;
      SCK = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] r);
    spi_bits(tx, 8, r);
  endtask

  task automatic cs_low();
    CSn = 1'b0;
    #80;
  endtask

  task automatic cs_high();
    #40;
    CSn = 1'b1;
    #120;
  endtask

  task automatic cmd_addr(input logic [7:0] op, input logic [23:0] addr);
    logic [7:0] d;
    xfer(op, d);
    xfer(addr[23:16], d);
    xfer(addr[15:8], d);
    xfer(addr[7:0], d);
  endtask

  task automatic wr1(input logic [23:0] addr, input logic [7:0] data);
    logic [7:0] d;
    cs_low();
    cmd_addr(8'h02, addr);
    xfer(data, d);
    cs_high();
  endtask

  task automatic rd1(input logic [23:0] addr, output logic [7:0] r);
    cs_low();
    cmd_addr(8'h03, addr);
    xfer(8'h00, r);
    cs_high();
  endtask

  task automatic wrmr(input logic [7:0] val);
    logic [7:0] d;
    cs_low();
    xfer(8'h01, d);
    xfer(val, d);
    cs_high();
  endtask

  initial begin
    rst = 1'b1;
    CSn = 1'b1;
    SCK = 1'b0;
    SI  = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_so", {7'd0, SO}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_mode", mode_reg, 8'h40);
    chk("rst_bad_cmd", {7'd0, bad_cmd}, 8'h00);
    rst = 1'b0;
    #40;

    // RDMR after reset, repeated on the second byte
    cs_low();
    xfer(8'h05, rx);
    xfer(8'h00, rx);
    chk("rdmr_byte0", rx, 8'h40);
    chk("busy_active", {7'd0, busy}, 8'h01);
    xfer(8'h00, rx);
    chk("rdmr_repeat", rx, 8'h40);
    cs_high();
    chk("so_idle", {7'd0, SO}, 8'h00);
    chk("busy_idle", {7'd0, busy}, 8'h00);

    // Known background values for the "unchanged" checks
    wr1(24'h000020, 8'h5E);
    wr1(24'h000006, 8'h66);
    wr1(24'h000041, 8'h41);

    // Burst write / burst read, then aliased address
    cs_low();
    cmd_addr(8'h02, 24'h000010);
    xfer(8'hA5, rx);
    xfer(8'h5A, rx);
    xfer(8'hC3, rx);
    cs_high();
    cs_low();
    cmd_addr(8'h03, 24'h000010);
    xfer(8'h00, rx); chk("rd_seq0", rx, 8'hA5);
    xfer(8'h00, rx); chk("rd_seq1", rx, 8'h5A);
    xfer(8'h00, rx); chk("rd_seq2", rx, 8'hC3);
    cs_high();
    rd1(24'h000410, rx);
    chk("rd_alias", rx, 8'hA5);

    // Sequential wrap at the top of memory
    cs_low();
    cmd_addr(8'h02, 24'h0003FF);
    xfer(8'h11, rx);
    xfer(8'h22, rx);
    cs_high();
    rd1(24'h0003FF, rx); chk("wrap_top", rx, 8'h11);
    rd1(24'h000000, rx); chk("wrap_zero", rx, 8'h22);

    // Page mode wraps inside the 32-byte page
    wrmr(8'h80);
    chk("mode_page", mode_reg, 8'h80);
    cs_low();
    cmd_addr(8'h02, 24'h00001F);
    xfer(8'h77, rx);
    xfer(8'h88, rx);
    cs_high();
    rd1(24'h00001F, rx); chk("page_1f", rx, 8'h77);
    rd1(24'h000000, rx); chk("page_00", rx, 8'h88);
    rd1(24'h000020, rx); chk("page_20_kept", rx, 8'h5E);

    // Byte mode: only the first byte counts
    wrmr(8'h00);
    chk("mode_byte", mode_reg, 8'h00);
    cs_low();
    cmd_addr(8'h02, 24'h000005);
    xfer(8'h99, rx);
    xfer(8'hEE, rx);
    cs_high();
    cs_low();
    cmd_addr(8'h03, 24'h000005);
    xfer(8'h00, rx); chk("byte_rd0", rx, 8'h99);
    xfer(8'h00, rx); chk("byte_rd1_zero", rx, 8'h00);
    cs_high();
    rd1(24'h000006, rx); chk("byte_06_kept", rx, 8'h66);

    // Partial byte discarded on CSn rise
    wrmr(8'h40);
    cs_low();
    cmd_addr(8'h02, 24'h000040);
    xfer(8'h3C, rx);
    spi_bits(8'hF0, 4, rx);
    cs_high();
    cs_low();
    cmd_addr(8'h03, 24'h000040);
    xfer(8'h00, rx); chk("abort_40", rx, 8'h3C);
    xfer(8'h00, rx); chk("abort_41_kept", rx, 8'h41);
    cs_high();

    // Unsupported opcode
    chk("bad_cmd_quiet", bad_cnt, 8'd0);
    snap = so_high_cnt;
    cs_low();
    xfer(8'h9F, rx);
    xfer(8'hFF, rx);
    chk("ignore_rx", rx, 8'h00);
    cs_high();
    chk("bad_cmd_once", bad_cnt, 8'd1);
    chk("ignore_so_low", so_high_cnt - snap, 8'd0);

    // Reset in the middle of a READ
    wrmr(8'hC0);
    chk("mode_11", mode_reg, 8'hC0);
    cs_low();
    cmd_addr(8'h03, 24'h000010);
    spi_bits(8'h00, 2, rx);
    chk("rd_mode11_bits", rx, 8'h80);
    #40;
    chk("so_before_rst", {7'd0, SO}, 8'h01);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_so", {7'd0, SO}, 8'h00);
    chk("midrst_mode", mode_reg, 8'h40);
    chk("midrst_busy", {7'd0, busy}, 8'h00);
    rst = 1'b0;
    #40;
    snap = so_high_cnt;
    xfer(8'h05, rx);
    xfer(8'h00, rx);
    chk("post_rst_ignored", rx, 8'h00);
    chk("post_rst_so_low", so_high_cnt - snap, 8'd0);
    cs_high();
    cs_low();
    xfer(8'h05, rx);
    xfer(8'h00, rx);
    chk("post_rst_rdmr", rx, 8'h40);
    cs_high();
    chk("bad_cmd_total", bad_cnt, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_sram_responder.md
Name: spi_sram_responder

Overview:
- SPI-mode-0 responder that emulates the 23LC1024 serial SRAM command set on an internal block RAM.
- Sits on the far end of the SRAM SPI pins, in place of the physical chip.
- Serves as the loopback target for the SRAM controller in simulation and on-board when no chip is fitted.
- All pins are oversampled in the system clock domain; no logic is clocked by SCK.

Parameters:
- ADDR_BITS, 10: internal memory depth is 2^ADDR_BITS bytes; the 24-bit SPI address is reduced modulo the depth.
- PAGE_BYTES, 32: page size for page mode; must be a power of two and no larger than 2^ADDR_BITS.

Ports:
- clk  input  1  system clock; must run at least 8x the SCK frequency.
- rst  input  1  synchronous, active-high reset.
- CSn  input  1  chip select, active low (asynchronous to clk).
- SCK  input  1  SPI clock (asynchronous to clk).
- SI  input  1  serial data in, MSB first.
- SO  output  1  serial data out, MSB first.
- busy  output  1  high while CSn is low (synchronised).
- mode_reg  output  8  current mode register.
- bad_cmd  output  1  one-cycle pulse when an unsupported opcode completes.

Behaviour:
- Synchroniser and edge detection:
  - CSn, SCK and SI each pass through 2-flop synchronisers.
  - Rising and falling SCK edges are detected from the synchronised SCK.
  - SI is sampled on a detected rising edge; SO changes only on a detected falling edge.
  - SO must update within 3 clk cycles of the physical SCK fall.
- Reset:
  - SO=0, busy=0, bad_cmd=0, mode_reg=8'h40 (sequential), FSM=IDLE, all counters cleared.
  - Memory contents are not cleared.
  - Reset mid-transaction aborts it; the block ignores the bus until the next CSn high-then-low.
- Opcodes (first 8 bits after CSn falls):
  - 0x03 READ, 0x02 WRITE: followed by 24 address bits.
  - 0x05 RDMR: read mode register.
  - 0x01 WRMR: write mode register.
  - Any other opcode: bad_cmd pulses once and the FSM enters IGNORE until CSn rises.
- FSM states: IDLE, CMD, ADDR, RD_DATA, WR_DATA, RDMR, WRMR, IGNORE.
  - IDLE -> CMD on synchronised CSn fall; bit counter cleared.
  - CMD -> ADDR / RDMR / WRMR / IGNORE on the 8th rising edge.
  - ADDR -> RD_DATA / WR_DATA on the 24th address rising edge.
  - Any state -> IDLE on synchronised CSn rise; SO driven 0 while in IDLE.
- READ:
  - The byte at the received address is fetched on the last address rising edge (1-cycle RAM latency).
  - Its MSB appears on SO at the next falling edge.
  - Each subsequent byte is fetched in time for its first falling edge.
- WRITE:
  - Each data byte is committed to RAM on its 8th rising edge.
  - CSn rising mid-byte discards the partial byte; earlier completed bytes remain written.
- Address advance after each byte, selected by mode_reg[7:6]:
  - 01 sequential: address+1, wrapping modulo 2^ADDR_BITS.
  - 10 page: low log2(PAGE_BYTES) bits increment and wrap; upper bits are held.
  - 00 byte: no advance. Further WRITE bytes are ignored; further READ bytes are driven as 0x00.
  - 11: treated as sequential.
- RDMR: mode_reg is shifted out on SO, repeated for every further byte clocked.
- WRMR: mode_reg is updated on the 8th data rising edge; additional bytes are ignored.
- Simultaneous events: a CSn rise detected in the same cycle as an SCK rise takes priority; no sample is taken.
- busy equals inverted synchronised CSn, gated to 0 during rst.

Test Plan:
1. After reset, RDMR (0x05) -> SO byte 0x40; mode_reg=0x40; bad_cmd never asserted.
2. WRITE 0x02, addr 0x000010, data A5 5A C3, CSn high; then READ 0x03 addr 0x000010, 3 bytes -> A5 5A C3. Also READ addr 0x000410 (ADDR_BITS=10) -> A5, from wrap-around aliasing.
3. Sequential wrap: WRITE at 0x0003FF bytes 11 22 -> READ 0x0003FF gives 11, READ 0x000000 gives 22.
4. WRMR 0x80 (page mode); WRITE at 0x00001F bytes 77 88 -> 0x1F=77, 0x00=88, and 0x20 is unchanged.
5. WRMR 0x00 (byte mode); WRITE 0x000005 bytes 99 EE; READ 0x000005 for 2 bytes -> 99 00; RAM at 0x06 unchanged.
6. Abort and error handling:
   - WRITE 0x000040 with one full byte 3C, then 4 more bits, then CSn high -> 0x40=3C and 0x41 unchanged.
   - Opcode 0x9F -> bad_cmd pulses once, SO stays 0.
   - rst asserted mid-READ -> SO=0, FSM=IDLE, mode_reg=0x40.
